qracc_adc_accumulator: RTL



---
 rtl/qracc_adc_accumulator.sv | 127 ++++++++++++
 1 files changed

// File: rtl/qracc_adc_accumulator.sv
// rtl/qracc_adc_accumulator.sv - bit-serial shift-accumulator for QRAcc column ADC planes
module qracc_adc_accumulator #(
    parameter int numCols         = 32,
    parameter int numAdcBits      = 4,
    parameter int compCount       = (2**numAdcBits)-1,
    parameter int accumulatorBits = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_i,
    input  logic [3:0]                           n_input_bits_cfg,
    input  logic                                 binary_cfg,
    input  logic                                 unsigned_acts,
    input  logic                                 adc_valid_i,
    input  logic [compCount*numCols-1:0]         adc_out_i,
    output logic [accumulatorBits*numCols-1:0]   acc_o,
    output logic                                 acc_valid_o,
    input  logic                                 acc_ready_i,
    output logic                                 busy_o,
    output logic                                 sample_drop_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DONE} state_t;

    localparam logic signed [accumulatorBits-1:0] COMP_S = accumulatorBits'(compCount);

    state_t state, state_nxt;
    logic [2:0] k, last_k;
    logic binary_q, unsigned_q;
    logic clear, accept, drop_nxt;
    logic signed [accumulatorBits-1:0] acc_q [numCols];
    logic signed [accumulatorBits-1:0] term  [numCols];
    logic [numAdcBits-1:0] pop;
    logic signed [accumulatorBits-1:0] pop_ext, v, shifted;

    // Plane count is stored as the index of the last plane (n-1), clamped to 0..7.
    function automatic logic [2:0] clamp_last(input logic [3:0] cfg);
        if (cfg == 4'd0)     return 3'd0;
        else if (cfg > 4'd8) return 3'd7;
        else                 return 3'(cfg - 4'd1);
    endfunction

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        accept    = 1'b0;
        drop_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                drop_nxt = adc_valid_i;
                if (start_i) begin
                    clear     = 1'b1;
                    state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (adc_valid_i) begin
                    accept = 1'b1;
                    if (k == last_k) state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                drop_nxt = adc_valid_i;
                if (acc_ready_i) begin
                    if (start_i) begin
                        clear     = 1'b1;
                        state_nxt = ST_ACCUM;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Thermometer decode by popcount, so comparator bubbles still count correctly.
    always_comb begin
        pop     = '0;
        pop_ext = '0;
        v       = '0;
        shifted = '0;
        for (int c = 0; c < numCols; c++) begin
            pop = '0;
            for (int b = 0; b < compCount; b++) begin
                pop = pop + numAdcBits'(adc_out_i[c*compCount + b]);
            end
            pop_ext = accumulatorBits'(pop);
            v       = binary_q ? pop_ext : (pop_ext <<< 1) - COMP_S;
            shifted = v <<< k;
            term[c] = (!unsigned_q && (k == last_k)) ? -shifted : shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            k             <= '0;
            last_k        <= '0;
            binary_q      <= 1'b0;
            unsigned_q    <= 1'b0;
            sample_drop_o <= 1'b0;
            for (int c = 0; c < numCols; c++) acc_q[c] <= '0;
        end else begin
            state         <= state_nxt;
            sample_drop_o <= drop_nxt;
            if (clear) begin
                k          <= '0;
                last_k     <= clamp_last(n_input_bits_cfg);
                binary_q   <= binary_cfg;
                unsigned_q <= unsigned_acts;
                for (int c = 0; c < numCols; c++) acc_q[c] <= '0;
            end else if (accept) begin
                k <= k + 3'd1;
                for (int c = 0; c < numCols; c++) acc_q[c] <= acc_q[c] + term[c];
            end
        end
    end

    for (genvar c = 0; c < numCols; c++) begin : g_pack
        assign acc_o[c*accumulatorBits +: accumulatorBits] = acc_q[c];
    end

    assign acc_valid_o = (state == ST_DONE);
    assign busy_o      = (state != ST_IDLE);

endmodule
